// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, bus field widths and a small
// address-compare helper used by the target core and bus models.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  // Address byte is {addr[6:0], rw}; only the upper seven bits identify the target.
  function automatic logic addr_match(input logic [I2C_BYTE_W-1:0] addr_byte,
                                      input logic [I2C_ADDR_W-1:0] own_addr);
    return addr_byte[I2C_BYTE_W-1:1] == own_addr;
  endfunction

endpackage

// File: rtl/i2c_slave_core_if.sv
// Pin and user-side signals of the I2C target, bundled for port connection.
interface i2c_slave_core_if;
  import i2c_pkg::*;

  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_oe;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  tx_req;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  busy;
  logic                  rw;

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_valid, rx_data, tx_req, busy, rw
  );

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_valid, rx_data, tx_req, busy, rw
  );

endinterface

// File: rtl/i2c_in_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only
// follows the synchronized input once it has differed for FILT samples.
module i2c_in_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clk domain; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], din};
  end

  // Accept a new level only after FILT consecutive samples disagree with the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 1'b1;
      cnt  <= '0;
    end else if (sync[1] == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILT - 1)) begin
      dout <= sync[1];
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_slave_core.sv
// I2C target core: filters SCL/SDA, detects START/STOP, matches a 7-bit
// address, ACKs, and turns bus bytes into rx_valid / tx_req strobes.
module i2c_slave_core
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDR = 7'h2a,
  parameter int                    FILT = 3
) (
  input logic              clk,
  input logic              rst_n,
  i2c_slave_core_if.slave  bus
);

  logic scl_f, sda_f;
  logic scl_d, sda_d;

  logic scl_rise, scl_fall, start_evt, stop_evt;

  i2c_state_t            state;
  logic [2:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shreg;
  logic [I2C_BYTE_W-1:0] shifted;

  logic                  sda_oe;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  tx_req;
  logic                  busy;
  logic                  rw;

  i2c_in_filter #(.FILT(FILT)) u_scl_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.scl_i),
    .dout (scl_f)
  );

  i2c_in_filter #(.FILT(FILT)) u_sda_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.sda_i),
    .dout (sda_f)
  );

  // Previous filtered levels for edge and START/STOP detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // SCL must be high in both samples so an SDA move right at an SCL edge
  // is never mistaken for START/STOP.
  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_evt =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_evt  =  scl_f &  scl_d & ~sda_d &  sda_f;

  assign shifted = {shreg[I2C_BYTE_W-2:0], sda_f};

  // Protocol FSM with registered outputs; START/STOP override bit events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      sda_oe   <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (start_evt) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_evt) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                if (addr_match(shifted, ADDR)) begin
                  rw    <= sda_f;
                  busy  <= 1'b1;
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_WAIT_STOP;
                end
              end
            end
          end
          // sda_oe doubles as the phase flag: first fall starts the ACK,
          // second fall ends the ACK clock.
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw) begin
                tx_req  <= 1'b1;
                shreg   <= bus.tx_data;
                sda_oe  <= ~bus.tx_data[I2C_BYTE_W-1];
                bit_cnt <= '0;
                state   <= ST_RD_BYTE;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WR_BYTE;
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= shifted;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) begin
                rx_data  <= shifted;
                rx_valid <= 1'b1;
                state    <= ST_WR_ACK;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_BYTE;
              end
            end
          end
          // shreg[7] is already on the bus; each fall presents the next bit.
          ST_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shreg[I2C_BYTE_W-2];
                shreg   <= {shreg[I2C_BYTE_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          // bit_cnt==1 records that the master ACKed on the 9th rise.
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_f) state   <= ST_WAIT_STOP;
              else       bit_cnt <= 3'd1;
            end else if (scl_fall && bit_cnt == 3'd1) begin
              tx_req  <= 1'b1;
              shreg   <= bus.tx_data;
              sda_oe  <= ~bus.tx_data[I2C_BYTE_W-1];
              bit_cnt <= '0;
              state   <= ST_RD_BYTE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.sda_oe   = sda_oe;
  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;
  assign bus.tx_req   = tx_req;
  assign bus.busy     = busy;
  assign bus.rw       = rw;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a bit-level bus master drives directed
// transactions while a transaction-level model predicts ACKs, received
// bytes, read bytes and strobe counts.
module tb_i2c_slave_core;
  import i2c_pkg::*;

  localparam int Q = 10;
  localparam logic [6:0] OWN = 7'h2a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_slave_core_if bus();

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic glitch = 1'b0;

  assign bus.scl_i = scl_m;
  assign bus.sda_i = (sda_m & ~bus.sda_oe) ^ glitch;

  i2c_slave_core #(.ADDR(OWN), .FILT(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_rx[$];
  int tx_pending = 0;
  int rx_seen = 0;
  int tx_seen = 0;
  bit drive_ok = 1'b0;
  bit prev_drv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("rx_tx_exclusive", 32'(bus.rx_valid & bus.tx_req), 32'd0);
    if (!drive_ok) chk("sda_oe_outside_slot", 32'(bus.sda_oe), 32'd0);
    if (bus.rx_valid) begin
      rx_seen++;
      if (exp_rx.size() == 0) chk("rx_valid_unexpected", 32'(exp_rx.size()), 32'd1);
      else chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
    end
    if (bus.tx_req) begin
      tx_seen++;
      chk("tx_req_expected", 32'(tx_pending > 0), 32'd1);
      if (tx_pending > 0) tx_pending--;
    end
  end

  // One SCL period; sdrv marks a slot where the target may pull SDA.
  task automatic bit_xfer(input logic b, input bit sdrv, input bit glt, output logic rd);
    scl_m = 1'b0;
    drive_ok = prev_drv | sdrv;
    tick(Q);
    drive_ok = sdrv;
    sda_m = sdrv ? 1'b1 : b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q / 2);
    if (glt) begin
      glitch = 1'b1;
      tick(1);
      glitch = 1'b0;
    end else begin
      tick(1);
    end
    tick(Q / 2 - 1);
    rd = bus.sda_i;
    tick(Q);
    prev_drv = sdrv;
  endtask

  task automatic do_start();
    scl_m = 1'b0;
    drive_ok = prev_drv;
    tick(Q);
    drive_ok = 1'b0;
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(2 * Q);
    sda_m = 1'b0;
    tick(2 * Q);
    prev_drv = 1'b0;
  endtask

  task automatic do_stop();
    scl_m = 1'b0;
    drive_ok = prev_drv;
    tick(Q);
    drive_ok = 1'b0;
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(2 * Q);
    sda_m = 1'b1;
    tick(2 * Q);
    prev_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit exp_ack, input logic [7:0] gmask,
                            input bit is_data);
    logic rd;
    if (is_data && exp_ack) exp_rx.push_back(d);
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], 1'b0, gmask[i], rd);
    bit_xfer(1'b1, exp_ack, 1'b0, rd);
    chk("ack_bit", 32'(rd), 32'(!exp_ack));
  endtask

  task automatic read_byte(input logic [7:0] exp, input bit mack);
    logic rd;
    logic [7:0] got;
    bus.tx_data = exp;
    tx_pending++;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b1, 1'b0, rd);
      got[i] = rd;
    end
    chk("read_byte", 32'(got), 32'(exp));
    bit_xfer(!mack, 1'b0, 1'b0, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rx0, tx0;
    logic rd;
    bus.tx_data = 8'h00;

    // Reset values
    tick(3);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'h00);
    chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rw", 32'(bus.rw), 32'd0);
    rst_n = 1'b1;
    tick(10);

    // Write 0x74 to own address
    rx0 = rx_seen;
    do_start();
    write_byte({OWN, 1'b0}, 1'b1, 8'h00, 1'b0);
    chk("t1_busy_after_addr", 32'(bus.busy), 32'd1);
    chk("t1_rw", 32'(bus.rw), 32'd0);
    write_byte(8'h74, 1'b1, 8'h00, 1'b1);
    do_stop();
    tick(10);
    chk("t1_busy_after_stop", 32'(bus.busy), 32'd0);
    chk("t1_rx_data", 32'(bus.rx_data), 32'h74);
    chk("t1_rx_count", 32'(rx_seen - rx0), 32'd1);
    chk("t1_state_idle", 32'(dut.state), 32'(ST_IDLE));

    // Read one byte 0xab, master NACKs
    tx0 = tx_seen;
    do_start();
    write_byte({OWN, 1'b1}, 1'b1, 8'h00, 1'b0);
    chk("t2_rw", 32'(bus.rw), 32'd1);
    chk("t2_busy", 32'(bus.busy), 32'd1);
    read_byte(8'hab, 1'b0);
    chk("t2_state_wait_stop", 32'(dut.state), 32'(ST_WAIT_STOP));
    do_stop();
    tick(10);
    chk("t2_tx_count", 32'(tx_seen - tx0), 32'd1);
    chk("t2_state_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("t2_busy_after_stop", 32'(bus.busy), 32'd0);

    // Address mismatch: no ACK, no strobes
    rx0 = rx_seen;
    do_start();
    write_byte({7'h2b, 1'b0}, 1'b0, 8'h00, 1'b0);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    write_byte(8'h55, 1'b0, 8'h00, 1'b1);
    do_stop();
    tick(10);
    chk("t3_rx_count", 32'(rx_seen - rx0), 32'd0);

    // Write 0x11, repeated START, read 0xab (ACK) and 0xcd (NACK)
    tx0 = tx_seen;
    do_start();
    write_byte({OWN, 1'b0}, 1'b1, 8'h00, 1'b0);
    write_byte(8'h11, 1'b1, 8'h00, 1'b1);
    do_start();
    write_byte({OWN, 1'b1}, 1'b1, 8'h00, 1'b0);
    read_byte(8'hab, 1'b1);
    read_byte(8'hcd, 1'b0);
    do_stop();
    tick(10);
    chk("t4_rx_data", 32'(bus.rx_data), 32'h11);
    chk("t4_tx_count", 32'(tx_seen - tx0), 32'd2);

    // SDA glitches while SCL high on a 1 bit and a 0 bit
    rx0 = rx_seen;
    do_start();
    write_byte({OWN, 1'b0}, 1'b1, 8'h00, 1'b0);
    write_byte(8'h74, 1'b1, 8'b0100_1000, 1'b1);
    do_stop();
    tick(10);
    chk("t5_rx_data", 32'(bus.rx_data), 32'h74);
    chk("t5_rx_count", 32'(rx_seen - rx0), 32'd1);

    // Reset during data bit 4 of a read of 0xab
    do_start();
    write_byte({OWN, 1'b1}, 1'b1, 8'h00, 1'b0);
    bus.tx_data = 8'hab;
    tx_pending++;
    bit_xfer(1'b1, 1'b1, 1'b0, rd);
    chk("t6_bit7", 32'(rd), 32'd1);
    bit_xfer(1'b1, 1'b1, 1'b0, rd);
    chk("t6_bit6", 32'(rd), 32'd0);
    bit_xfer(1'b1, 1'b1, 1'b0, rd);
    chk("t6_bit5", 32'(rd), 32'd1);
    scl_m = 1'b0;
    drive_ok = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    chk("t6_bit4_driven", 32'(bus.sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_rw", 32'(bus.rw), 32'd0);
    drive_ok = 1'b0;
    prev_drv = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(Q);
    do_stop();
    tick(10);
    rx0 = rx_seen;
    do_start();
    write_byte({OWN, 1'b0}, 1'b1, 8'h00, 1'b0);
    write_byte(8'h74, 1'b1, 8'h00, 1'b1);
    do_stop();
    tick(10);
    chk("t6_rx_data", 32'(bus.rx_data), 32'h74);
    chk("t6_rx_count", 32'(rx_seen - rx0), 32'd1);
    chk("t6_busy", 32'(bus.busy), 32'd0);

    // Model drained
    chk("end_tx_pending", 32'(tx_pending), 32'd0);
    chk("end_rx_pending", 32'(exp_rx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
